// File: rtl/pipelined_dp_ram_pkg.sv
// Shared definitions for the pipelined dual-port RAM.
// - state_e : controller states (ST_CLEAR zeroes the array, ST_READY serves accesses)
// - RD_LAT_* : the two supported read latencies
package pipelined_dp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

endpackage

// File: rtl/pipelined_dp_ram_core.sv
// dp_ram_core: plain storage array.
// Writes are synchronous with per-lane enables. The read port is asynchronous
// (combinational), so all read timing is owned by the enclosing controller.
// Ports:
//   clk   - clock
//   we    - write strobe
//   be    - per-lane write enable
//   waddr - write address (must be < RAM_DEPTH when we=1)
//   wdata - write data
//   raddr - read address
//   rdata - read data for raddr, combinational
module dp_ram_core #(
    parameter int RAM_WIDTH  = 32,
    parameter int LANE_WIDTH = 8,
    parameter int RAM_DEPTH  = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [RAM_WIDTH/LANE_WIDTH-1:0]     be,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [RAM_WIDTH-1:0]                wdata,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    output logic [RAM_WIDTH-1:0]                rdata
);

    localparam int NUM_LANES = RAM_WIDTH / LANE_WIDTH;

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (be[l]) begin
                    mem[waddr][l*LANE_WIDTH +: LANE_WIDTH] <= wdata[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipelined_dp_ram.sv
// pipelined_dp_ram: byte-enable dual-port RAM with a self-clearing controller
// and a 1- or 2-stage registered read path.
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   wr_en/wr_be/wr_addr/data_in - write port with per-lane enables
//   rd_en/rd_addr     - read request
//   clr_req           - pulse: re-zero the whole array
//   data_out/rd_valid - registered read data and its one-cycle strobe
//   init_done         - 1 once the array is cleared and accessible
//   addr_err          - one-cycle strobe for a rejected out-of-range access
module pipelined_dp_ram
    import pipelined_dp_ram_pkg::*;
#(
    parameter int RAM_WIDTH   = 32,
    parameter int LANE_WIDTH  = 8,
    parameter int RAM_DEPTH   = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [RAM_WIDTH/LANE_WIDTH-1:0]     wr_be,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [RAM_WIDTH-1:0]                data_in,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    input  logic                                clr_req,
    output logic [RAM_WIDTH-1:0]                data_out,
    output logic                                rd_valid,
    output logic                                init_done,
    output logic                                addr_err
);

    localparam int NUM_LANES = RAM_WIDTH / LANE_WIDTH;
    // One extra bit so RAM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_addr_q, clr_addr_d;
    logic                   ready;
    logic                   wr_ok, rd_ok, wr_acc, rd_acc;

    logic                   mem_we;
    logic [NUM_LANES-1:0]   mem_be;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [RAM_WIDTH-1:0]   mem_wdata;
    logic [RAM_WIDTH-1:0]   mem_rdata;

    logic                   rd_vld_p0;
    logic [RAM_WIDTH-1:0]   rd_data_p0;
    logic                   err_p0;
    logic                   last_vld;
    logic [RAM_WIDTH-1:0]   last_data;

    logic [RAM_WIDTH-1:0]   data_out_q;
    logic                   rd_valid_q;
    logic                   addr_err_q;

    assign ready  = (state_q == ST_READY);
    assign wr_ok  = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_ok  = ({1'b0, rd_addr} < DEPTH_EXT);
    assign wr_acc = ready & wr_en;
    assign rd_acc = ready & rd_en;

    // While clearing, the controller owns the write port and zeroes one word per cycle.
    assign mem_we    = ready ? (wr_acc & wr_ok) : 1'b1;
    assign mem_be    = ready ? wr_be : '1;
    assign mem_waddr = ready ? wr_addr : clr_addr_q;
    assign mem_wdata = ready ? data_in : '0;

    dp_ram_core #(
        .RAM_WIDTH  (RAM_WIDTH),
        .LANE_WIDTH (LANE_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // ---- stage p0: address check and optional same-address write forwarding ----
    always_comb begin
        rd_data_p0 = mem_rdata;
        if ((WRITE_FIRST != 0) && wr_acc && wr_ok && (wr_addr == rd_addr)) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wr_be[l]) begin
                    rd_data_p0[l*LANE_WIDTH +: LANE_WIDTH] = data_in[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        if (!rd_ok) begin
            rd_data_p0 = '0;
        end
    end

    assign rd_vld_p0 = rd_acc;
    assign err_p0    = (wr_acc & ~wr_ok) | (rd_acc & ~rd_ok);

    // ---- stage p1: extra register only for the two-cycle read latency ----
    if (RD_LATENCY == RD_LAT_2) begin : g_lat2
        logic                 rd_vld_p1_q;
        logic [RAM_WIDTH-1:0] rd_data_p1_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_vld_p1_q <= 1'b0;
            end else begin
                rd_vld_p1_q <= rd_vld_p0;
            end
        end

        always_ff @(posedge clk) begin
            if (rd_vld_p0) begin
                rd_data_p1_q <= rd_data_p0;
            end
        end

        assign last_vld  = rd_vld_p1_q;
        assign last_data = rd_data_p1_q;
    end else begin : g_lat1
        assign last_vld  = rd_vld_p0;
        assign last_data = rd_data_p0;
    end

    // ---- output stage: data_out only loads with a valid word, otherwise holds ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rd_valid_q <= last_vld;
            addr_err_q <= err_p0;
            if (last_vld) begin
                data_out_q <= last_data;
            end
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;
    assign init_done = ready;

endmodule
